// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
// Module   : sat_accum
// Brief    : Saturating block accumulator with valid/ready in and out ports.
//            Optional sticky saturation flag: SAT_ACCUM_SAT_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sat_accum #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_sat_sum;
  logic             w_accept;
  logic             w_take;

  assign in_ready  = (r_state == c_idle) || (r_state == c_accum);
  assign out_valid = (r_state == c_done);
  // acc never changes in DONE, so it doubles as the held output register
  assign out_data  = r_acc;

  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;
  assign w_len_eff = (len == '0) ? LEN_W'(1) : len;
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
  assign w_carry   = w_sum[WIDTH];
  assign w_sat_sum = w_carry ? '1 : w_sum[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_nxt = (w_len_eff == LEN_W'(1)) ? c_done : c_accum;
      c_accum: if (w_accept && (w_cnt_inc == r_len_q)) w_state_nxt = c_done;
      c_done:  if (w_take) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (r_state == c_idle) begin
          r_acc   <= in_data;
          r_cnt   <= LEN_W'(1);
          r_len_q <= w_len_eff;
        end else begin
          r_acc   <= w_sat_sum;
          r_cnt   <= w_cnt_inc;
        end
      end
    end
  end

`ifdef SAT_ACCUM_SAT_FLAG_EN
  logic r_flag;
  logic r_out_sat;

  // r_flag tracks the block in flight; r_out_sat is the copy shown in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag    <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (w_accept) begin
      if (r_state == c_idle) begin
        r_flag    <= 1'b0;
        r_out_sat <= 1'b0;
      end else begin
        r_flag <= r_flag | w_carry;
        if (w_state_nxt == c_done) r_out_sat <= r_flag | w_carry;
      end
    end else if (w_take) begin
      r_out_sat <= 1'b0;
    end
  end

  assign out_sat = r_out_sat;
`else
  assign out_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sat_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_accum
// Brief    : Self-checking bench for sat_accum against a sum/clamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sat_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned q[$];

  sat_accum #(.WIDTH(8), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the saturating sum of non-negative samples is min(total, max),
  // and some addition carried exactly when the true total exceeds max.
  function automatic int unsigned model_data(input int unsigned total);
    return (total > 255) ? 255 : total;
  endfunction

  function automatic logic model_sat(input int unsigned total);
`ifdef SAT_ACCUM_SAT_FLAG_EN
    return total > 255;
`else
    return 1'b0;
`endif
  endfunction

  // Sends q as one block of length l, with gap bubbles between samples and
  // hold cycles of backpressure before the take.
  task automatic run_block(input logic [3:0] l, input int gap, input int hold, input string tag);
    int          eff;
    int unsigned total;
    eff   = (l == 4'd0) ? 1 : int'(l);
    total = 0;
    out_ready = 1'b0;
    for (int i = 0; i < eff; i++) begin
      for (int b = 0; b < ((i == 0) ? 0 : gap); b++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        len      = 4'($urandom);
      end
      @(negedge clk);
      chk($sformatf("%s in_ready s%0d", tag, i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("%s out_valid s%0d", tag, i), {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'(q[i]);
      len      = (i == 0) ? l : 4'($urandom);
      total   += q[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " out_data"}, {24'd0, out_data}, model_data(total));
    chk({tag, " out_sat"}, {31'd0, out_sat}, {31'd0, model_sat(total)});
    chk({tag, " in_ready done"}, {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      chk($sformatf("%s hold_valid h%0d", tag, h), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s hold_data h%0d", tag, h), {24'd0, out_data}, model_data(total));
      chk($sformatf("%s hold_sat h%0d", tag, h), {31'd0, out_sat}, {31'd0, model_sat(total)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready after take"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, " rst out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " rst out_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, " rst out_sat"}, {31'd0, out_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int l;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; len = 4'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", {24'd0, out_data}, 32'd0);
    chk("reset out_sat", {31'd0, out_sat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    q = '{10, 20, 30};          run_block(4'd3, 0, 0, "basic");
    q = '{200, 100};            run_block(4'd2, 0, 1, "sat");
    q = '{5};                   run_block(4'd1, 0, 0, "after_sat");
    q = '{8'h55};               run_block(4'd0, 0, 0, "zero_len");
    q = '{1, 2, 3, 4};          run_block(4'd4, 2, 5, "bubbles");
    q = '{255, 0, 0};           run_block(4'd3, 1, 0, "ff_plus_zero");

    // Partial block discarded by an asynchronous reset
    @(negedge clk); in_valid = 1'b1; in_data = 8'd50; len = 4'd4;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd60; len = 4'd1;
    @(negedge clk); in_valid = 1'b0;
    reset_pulse("midblock");
    q = '{7, 8};                run_block(4'd2, 0, 0, "post_reset");

    // Reset while a saturated total is being presented
    q = '{200, 100};
    @(negedge clk); in_valid = 1'b1; in_data = 8'd200; len = 4'd2;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd100;
    @(negedge clk); in_valid = 1'b0;
    chk("done_reset pre valid", {31'd0, out_valid}, 32'd1);
    reset_pulse("done_reset");
    q = '{3};                   run_block(4'd1, 0, 0, "post_reset2");

    for (int k = 0; k < 40; k++) begin
      l = $urandom_range(0, 7);
      q = {};
      for (int s = 0; s < 8; s++)
        q.push_back($urandom_range(0, 1) ? $urandom_range(100, 255) : $urandom_range(0, 40));
      run_block(4'(l), $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
